// File: rtl/histo_eq_sequencer_pkg.sv
// Shared types and default sizes for the histogram-equalization frame sequencer.
package histo_eq_pkg;

  localparam int DefDataWidth      = 8;
  localparam int DefNumberOfLevels = 1 << DefDataWidth;
  localparam int DefFramePixels    = 640 * 480;
  localparam int DefHistoWidth     = $clog2(DefFramePixels);

  // EQ_WAIT watchdog: width and number of cycles tolerated before giving up.
  localparam int WdWidth      = 12;
  localparam int TimeoutLimit = 4095;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    CDF,
    EQ_START,
    EQ_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/histo_eq_sequencer_cdf_accumulator.sv
// Running cumulative sum over histogram reads; writes trail the read by one cycle
// and the first non-zero sum of the frame is captured as cdf_min.
module cdf_accumulator
  import histo_eq_pkg::*;
#(
  parameter int DataWidth  = DefDataWidth,
  parameter int HistoWidth = DefHistoWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  rd_en,
  input  logic [DataWidth-1:0]  rd_addr,
  input  logic [HistoWidth-1:0] rd_data,
  output logic                  cum_we,
  output logic [DataWidth-1:0]  cum_wr_addr,
  output logic [HistoWidth-1:0] cum_wr_data,
  output logic [HistoWidth-1:0] cdf_min
);

  logic [HistoWidth-1:0] sum;
  logic [HistoWidth-1:0] sum_now;
  logic                  we_d;
  logic [DataWidth-1:0]  addr_d;
  logic                  min_found;

  // Read data arrives the cycle after the strobe, so the sum is formed in that cycle.
  assign sum_now     = sum + rd_data;
  assign cum_we      = we_d;
  assign cum_wr_addr = addr_d;
  assign cum_wr_data = we_d ? sum_now : {HistoWidth{1'b0}};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum       <= {HistoWidth{1'b0}};
      we_d      <= 1'b0;
      addr_d    <= {DataWidth{1'b0}};
      min_found <= 1'b0;
      cdf_min   <= {HistoWidth{1'b0}};
    end else begin
      we_d   <= rd_en;
      addr_d <= rd_en ? rd_addr : {DataWidth{1'b0}};
      if (we_d) begin
        sum <= sum_now;
        if (!min_found && (sum_now != {HistoWidth{1'b0}})) begin
          min_found <= 1'b1;
          cdf_min   <= sum_now;
        end
      end
    end
  end

endmodule

// File: rtl/histo_eq_sequencer.sv
// Frame controller: CLEAR -> ACCUM -> CDF -> EQ_START -> EQ_WAIT -> DONE.
// Optional EQ_WAIT watchdog and eq_timeout port when HISTO_EQ_TIMEOUT_EN is defined.
module histo_eq_sequencer
  import histo_eq_pkg::*;
#(
  parameter int DataWidth      = DefDataWidth,
  parameter int NumberOfLevels = DefNumberOfLevels,
  parameter int HistoWidth     = DefHistoWidth,
  parameter int FramePixels    = DefFramePixels
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  pixel_valid,
  input  logic [HistoWidth-1:0] hist_rd_data,
  input  logic                  eq_done,
  output logic                  busy,
  output logic [DataWidth-1:0]  bin_addr,
  output logic                  hist_clr_we,
  output logic                  accum_en,
  output logic                  hist_rd_en,
  output logic                  cum_we,
  output logic [DataWidth-1:0]  cum_wr_addr,
  output logic [HistoWidth-1:0] cum_wr_data,
  output logic [HistoWidth-1:0] cdf_min,
  output logic                  start_equalization,
  output logic                  lut_valid
`ifdef HISTO_EQ_TIMEOUT_EN
  ,
  output logic                  eq_timeout
`endif
);

  localparam int CntW = $clog2(FramePixels + 1);
  localparam logic [DataWidth:0] BinLast  = (DataWidth + 1)'(NumberOfLevels - 1);
  localparam logic [DataWidth:0] BinDrain = (DataWidth + 1)'(NumberOfLevels);
  localparam logic [CntW-1:0]    PixLast  = CntW'(FramePixels - 1);

  state_t             state;
  state_t             state_next;
  logic [DataWidth:0] bin_cnt;
  logic [DataWidth:0] bin_cnt_next;
  logic [CntW-1:0]    pix_cnt;
  logic [CntW-1:0]    pix_cnt_next;
  logic               clr_start;

`ifdef HISTO_EQ_TIMEOUT_EN
  localparam logic [WdWidth-1:0] WdLast = WdWidth'(TimeoutLimit - 1);
  logic [WdWidth-1:0] wd_cnt;
  logic [WdWidth-1:0] wd_cnt_next;
  logic               timeout_hit;
`endif

  // Next-state and counter logic.
  always_comb begin
    state_next   = state;
    bin_cnt_next = bin_cnt;
    pix_cnt_next = pix_cnt;
    clr_start    = 1'b0;
`ifdef HISTO_EQ_TIMEOUT_EN
    wd_cnt_next  = {WdWidth{1'b0}};
    timeout_hit  = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        if (frame_start) begin
          state_next   = CLEAR;
          bin_cnt_next = {(DataWidth + 1){1'b0}};
          clr_start    = 1'b1;
        end else begin
          state_next = state;
        end
      end
      CLEAR: begin
        if (bin_cnt == BinLast) begin
          state_next   = ACCUM;
          bin_cnt_next = {(DataWidth + 1){1'b0}};
          pix_cnt_next = {CntW{1'b0}};
        end else begin
          bin_cnt_next = bin_cnt + 1'b1;
        end
      end
      ACCUM: begin
        if (pixel_valid && (pix_cnt == PixLast)) begin
          state_next   = CDF;
          pix_cnt_next = {CntW{1'b0}};
          bin_cnt_next = {(DataWidth + 1){1'b0}};
        end else if (pixel_valid) begin
          pix_cnt_next = pix_cnt + 1'b1;
        end else begin
          pix_cnt_next = pix_cnt;
        end
      end
      CDF: begin
        // One extra drain cycle lets the last read's write land.
        if (bin_cnt == BinDrain) begin
          state_next   = EQ_START;
          bin_cnt_next = {(DataWidth + 1){1'b0}};
        end else begin
          bin_cnt_next = bin_cnt + 1'b1;
        end
      end
      EQ_START: begin
        state_next = EQ_WAIT;
      end
      EQ_WAIT: begin
        if (eq_done) begin
          state_next = DONE;
        end
`ifdef HISTO_EQ_TIMEOUT_EN
        else if (wd_cnt == WdLast) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end else begin
          wd_cnt_next = wd_cnt + 1'b1;
        end
`else
        else begin
          state_next = EQ_WAIT;
        end
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counters and registered phase outputs (decoded from the next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      bin_cnt            <= {(DataWidth + 1){1'b0}};
      pix_cnt            <= {CntW{1'b0}};
      busy               <= 1'b0;
      bin_addr           <= {DataWidth{1'b0}};
      hist_clr_we        <= 1'b0;
      accum_en           <= 1'b0;
      hist_rd_en         <= 1'b0;
      start_equalization <= 1'b0;
      lut_valid          <= 1'b0;
    end else begin
      state              <= state_next;
      bin_cnt            <= bin_cnt_next;
      pix_cnt            <= pix_cnt_next;
      busy               <= (state_next != IDLE) && (state_next != DONE);
      bin_addr           <= ((state_next == CLEAR) || (state_next == CDF)) ?
                            bin_cnt_next[DataWidth-1:0] : {DataWidth{1'b0}};
      hist_clr_we        <= (state_next == CLEAR);
      accum_en           <= (state_next == ACCUM);
      hist_rd_en         <= (state_next == CDF) && (bin_cnt_next != BinDrain);
      start_equalization <= (state_next == EQ_START);
      lut_valid          <= (state_next == DONE);
    end
  end

`ifdef HISTO_EQ_TIMEOUT_EN
  // Watchdog count and sticky timeout flag, cleared by the next accepted frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt     <= {WdWidth{1'b0}};
      eq_timeout <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_next;
      if (clr_start) begin
        eq_timeout <= 1'b0;
      end else if (timeout_hit) begin
        eq_timeout <= 1'b1;
      end
    end
  end
`endif

  cdf_accumulator #(
    .DataWidth  (DataWidth),
    .HistoWidth (HistoWidth)
  ) u_cdf (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr_start),
    .rd_en       (hist_rd_en),
    .rd_addr     (bin_addr),
    .rd_data     (hist_rd_data),
    .cum_we      (cum_we),
    .cum_wr_addr (cum_wr_addr),
    .cum_wr_data (cum_wr_data),
    .cdf_min     (cdf_min)
  );

endmodule

// File: tb/tb_histo_eq_sequencer.sv
// Bench for histo_eq_sequencer with a behavioural histogram RAM and a CDF-write scoreboard.
module tb_histo_eq_sequencer;

  localparam int DW = 8;
  localparam int NL = 256;
  localparam int HW = 19;
  localparam int FP = 768;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          pixel_valid;
  logic [HW-1:0] hist_rd_data;
  logic          eq_done;
  logic          busy;
  logic [DW-1:0] bin_addr;
  logic          hist_clr_we;
  logic          accum_en;
  logic          hist_rd_en;
  logic          cum_we;
  logic [DW-1:0] cum_wr_addr;
  logic [HW-1:0] cum_wr_data;
  logic [HW-1:0] cdf_min;
  logic          start_equalization;
  logic          lut_valid;
`ifdef HISTO_EQ_TIMEOUT_EN
  logic          eq_timeout;
`endif
  logic [DW-1:0] pix_val;

  always #5 clk = ~clk;

  histo_eq_sequencer #(
    .DataWidth(DW), .NumberOfLevels(NL), .HistoWidth(HW), .FramePixels(FP)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .hist_rd_data(hist_rd_data), .eq_done(eq_done), .busy(busy), .bin_addr(bin_addr),
    .hist_clr_we(hist_clr_we), .accum_en(accum_en), .hist_rd_en(hist_rd_en),
    .cum_we(cum_we), .cum_wr_addr(cum_wr_addr), .cum_wr_data(cum_wr_data),
    .cdf_min(cdf_min), .start_equalization(start_equalization), .lut_valid(lut_valid)
`ifdef HISTO_EQ_TIMEOUT_EN
    , .eq_timeout(eq_timeout)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Histogram RAM: clear port, external increment path, 1-cycle read.
  logic [HW-1:0] hram [NL];
  always @(posedge clk) begin
    if (hist_clr_we) hram[bin_addr] <= '0;
    if (accum_en && pixel_valid) hram[pix_val] <= hram[pix_val] + 1'b1;
    hist_rd_data <= hist_rd_en ? hram[bin_addr] : '0;
  end

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  clr_idx;
  int  last_cum;
  wr_t e;

  // Scoreboard pop on every CDF write and CLEAR address sequence check.
  always @(negedge clk) begin
    if (cum_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cum_we", 64'(cum_we), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("cum_addr", 64'(cum_wr_addr), 64'(e.addr));
        check("cum_data", 64'(cum_wr_data), 64'(e.data));
        last_cum = int'(cum_wr_data);
      end
    end
    if (hist_clr_we) begin
      check("clr_addr", 64'(bin_addr), 64'(clr_idx));
      clr_idx++;
    end
  end

  function automatic int pix_of(input int mode, input int i);
    case (mode)
      0:       return i % NL;
      1:       return 100;
      2:       return (i % 2 != 0) ? 255 : 17;
      default: return 0;
    endcase
  endfunction

  task automatic prep_expect(input int mode);
    int h[NL];
    int cum;
    for (int k = 0; k < NL; k++) h[k] = 0;
    for (int i = 0; i < FP; i++) h[pix_of(mode, i)]++;
    cum = 0;
    for (int k = 0; k < NL; k++) begin
      cum += h[k];
      exp_q.push_back('{addr: k, data: cum});
    end
    last_cum = 0;
  endtask

  // Runs one frame from frame_start up to the first EQ_WAIT cycle.
  task automatic to_eq_wait(input int mode, input int gap, input bit noisy);
    int n;
    prep_expect(mode);
    clr_idx = 0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    n = 0;
    while (hist_clr_we && n < 400) begin
      n++;
      pixel_valid = noisy;
      pix_val     = 8'd7;
      eq_done     = noisy;
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    eq_done     = 1'b0;
    check("clear_cycles", 64'(n), 64'd256);
    check("accum_en_on", 64'(accum_en), 64'd1);
    for (int i = 0; i < FP; i++) begin
      for (int g = 0; g < gap; g++) begin
        pixel_valid = 1'b0;
        @(negedge clk);
      end
      if (i == FP - 1) check("accum_before_last", 64'(accum_en), 64'd1);
      pixel_valid = 1'b1;
      pix_val     = 8'(pix_of(mode, i));
      eq_done     = noisy && (i == 10);
      @(negedge clk);
      eq_done = 1'b0;
    end
    pixel_valid = 1'b0;
    check("accum_off_after_last", 64'(accum_en), 64'd0);
    check("rd_en_on", 64'(hist_rd_en), 64'd1);
    check("rd_addr0", 64'(bin_addr), 64'd0);
    n = 0;
    while (!start_equalization && n < 400) begin
      n++;
      frame_start = noisy && (n == 100);
      @(negedge clk);
    end
    frame_start = 1'b0;
    check("cdf_cycles", 64'(n), 64'd257);
    check("start_eq", 64'(start_equalization), 64'd1);
    @(negedge clk);
    check("start_eq_one_shot", 64'(start_equalization), 64'd0);
    check("busy_eq_wait", 64'(busy), 64'd1);
  endtask

  typedef struct { int mode; int gap; bit noisy; int exp_min; int exp_last; } vec_t;
  vec_t vecs[4];

  initial begin
    int n;
    vecs[0] = '{mode: 0, gap: 0, noisy: 1'b0, exp_min: 3,   exp_last: 768};
    vecs[1] = '{mode: 1, gap: 0, noisy: 1'b1, exp_min: 768, exp_last: 768};
    vecs[2] = '{mode: 0, gap: 2, noisy: 1'b0, exp_min: 3,   exp_last: 768};
    vecs[3] = '{mode: 2, gap: 0, noisy: 1'b0, exp_min: 384, exp_last: 768};

    rst = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0; eq_done = 1'b0; pix_val = '0;
    clr_idx = 0; last_cum = 0;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({busy, bin_addr, hist_clr_we, accum_en, hist_rd_en, cum_we,
                             cum_wr_addr, cum_wr_data, cdf_min, start_equalization, lut_valid}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Abort in the middle of ACCUM.
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n = 0;
    while (!accum_en && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("abort_reach_accum", 64'(accum_en), 64'd1);
    for (int i = 0; i < 300; i++) begin
      pixel_valid = 1'b1;
      pix_val     = 8'(i);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_outs", 64'({busy, bin_addr, hist_clr_we, accum_en, hist_rd_en, cum_we,
                             cum_wr_addr, cum_wr_data, cdf_min, start_equalization, lut_valid}), 64'd0);
    rst = 1'b0;
    pixel_valid = 1'b0;
    repeat (300) @(negedge clk);
    check("abort_stays_idle", 64'({busy, hist_rd_en, hist_clr_we}), 64'd0);

    for (int k = 0; k < 4; k++) begin
      to_eq_wait(vecs[k].mode, vecs[k].gap, vecs[k].noisy);
      check("cdf_min", 64'(cdf_min), 64'(vecs[k].exp_min));
      check("last_cum", 64'(last_cum), 64'(vecs[k].exp_last));
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      check("lut_invalid_wait", 64'(lut_valid), 64'd0);
      if (vecs[k].noisy) begin
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("fs_ignored_wait", 64'({busy, hist_clr_we}), 64'd2);
      end
      repeat (3) @(negedge clk);
      eq_done = 1'b1;
      @(negedge clk);
      eq_done = 1'b0;
      check("lut_valid_done", 64'({lut_valid, busy}), 64'd2);
      repeat (2) @(negedge clk);
      check("lut_valid_held", 64'(lut_valid), 64'd1);
    end

`ifdef HISTO_EQ_TIMEOUT_EN
    to_eq_wait(0, 0, 1'b0);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("timeout_cycles", 64'(n), 64'd4095);
    check("timeout_flag", 64'(eq_timeout), 64'd1);
    check("timeout_idle", 64'({lut_valid, hist_clr_we, busy}), 64'd0);
    clr_idx = 0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("timeout_cleared", 64'({eq_timeout, hist_clr_we}), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/histo_eq_sequencer.md
Name: histo_eq_sequencer

Overview:
- Frame-level controller for the histogram-equalization pipeline.
- Each frame runs four phases in order: clear histogram RAM, accumulate pixel counts, build the cumulative histogram (CDF) and its minimum non-zero value, then start the equalizer and wait for it.
- Owns the histogram/CDF RAM address bus and all phase enables. Presents `cdf_min` and `start_equalization` to the equalizer and raises `lut_valid` when the remap LUT is usable.

Parameters:
- DataWidth, 8, pixel / bin-index width.
- NumberOfLevels, 256, number of histogram bins (2**DataWidth).
- HistoWidth, $clog2(640*480) = 19, bin count / CDF width.
- FramePixels, 640*480, pixels per frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  pulse; requests processing of a new frame.
- pixel_valid  in  1  one qualified input pixel this cycle (ACCUM only).
- hist_rd_data  in  HistoWidth  histogram RAM read data, 1-cycle read latency.
- eq_done  in  1  equalizer completion pulse.
- busy  out  1  high in every state except IDLE and DONE.
- bin_addr  out  DataWidth  histogram/CDF RAM address while clearing or walking bins.
- hist_clr_we  out  1  write zero to histogram[bin_addr].
- accum_en  out  1  enables the external histogram increment path.
- hist_rd_en  out  1  histogram read strobe.
- cum_we  out  1  write `cum_wr_data` to CDF[cum_wr_addr].
- cum_wr_addr  out  DataWidth  CDF write address (the read address delayed 1 cycle).
- cum_wr_data  out  HistoWidth  running cumulative sum.
- cdf_min  out  HistoWidth  first non-zero CDF value of the frame.
- start_equalization  out  1  one-cycle pulse to the equalizer.
- lut_valid  out  1  equalized LUT is valid for the current frame.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; counters 0.
  - Reset asserted in any state aborts the frame immediately, with no further RAM writes.
- IDLE:
  - `frame_start` -> CLEAR.
  - `lut_valid` is cleared on entry to CLEAR.
- CLEAR:
  - `hist_clr_we` = 1; `bin_addr` goes 0..NumberOfLevels-1, one per cycle (256 cycles).
  - After the last address -> ACCUM.
- ACCUM:
  - `accum_en` = 1; pixel counter increments on each `pixel_valid`.
  - When the count reaches FramePixels (on the accepting cycle) -> CDF, with `accum_en` low the next cycle.
- CDF:
  - `hist_rd_en` = 1; `bin_addr` sweeps 0..255.
  - Each returned datum is added to the running sum (HistoWidth; cannot overflow since the total is ≤ FramePixels).
  - `cum_we`, `cum_wr_addr` and `cum_wr_data` are asserted 1 cycle after the matching read.
  - Duration: 257 cycles (256 reads plus 1 drain cycle).
  - `cdf_min` latches the first non-zero running sum; it stays 0 if the whole frame sums to 0.
  - After the last write -> EQ_START.
- EQ_START: `start_equalization` = 1 for exactly one cycle -> EQ_WAIT.
- EQ_WAIT: `eq_done` -> DONE.
- DONE:
  - `lut_valid` = 1 and held until the next `frame_start`.
  - Next `frame_start` -> CLEAR (that cycle counts as the IDLE transition).
- `frame_start` in any state other than IDLE/DONE is ignored; no queueing.
- `pixel_valid` outside ACCUM is ignored; no count is taken.
- `eq_done` outside EQ_WAIT is ignored.
- Total latency from `frame_start` to `start_equalization`: 256 + (cycles to receive FramePixels pixels) + 257 + 1.

Optional Feature:
- Macro: `HISTO_EQ_TIMEOUT_EN`.
- Defined:
  - Adds output `eq_timeout` (1 bit, reset 0) and a 12-bit watchdog in EQ_WAIT.
  - If `eq_done` has not arrived after 4095 cycles: `eq_timeout` = 1 (sticky until reset or the next `frame_start`), state -> IDLE, `lut_valid` stays 0.
- Undefined: no port, no counter; EQ_WAIT waits indefinitely.

Decomposition:
- Shared package `histo_eq_pkg`:
  - state enum (IDLE, CLEAR, ACCUM, CDF, EQ_START, EQ_WAIT, DONE);
  - DataWidth, NumberOfLevels, HistoWidth and FramePixels defaults;
  - timeout limit constant.
- One natural sub-module, `cdf_accumulator`:
  - running sum, 1-cycle address/valid delay, `cdf_min` capture;
  - cleared on CLEAR entry.
- The FSM and counters stay in the top level.

Test Plan:
- Reset mid-ACCUM (after 1000 pixels) -> next cycle all outputs 0, state IDLE, no `cum_we` seen.
- Uniform frame, all 256 bins = 1200 each (307200 pixels) -> `cum_wr_data` at address k = 1200*(k+1); `cdf_min` = 1200; single `start_equalization` pulse; `lut_valid` after `eq_done`.
- Frame with all pixels = 100 (RAM model returns 307200 at bin 100) -> CDF = 0 for bins 0..99 and 307200 for bins 100..255; `cdf_min` = 307200.
- `pixel_valid` gapped 1-in-3 -> CDF entered exactly on the 307200th accepted pixel; CLEAR lasts exactly 256 cycles with `hist_clr_we` on addresses 0..255.
- `frame_start` asserted during CDF and during EQ_WAIT, plus `eq_done` during ACCUM -> all ignored; the sequence completes normally once.
- With `HISTO_EQ_TIMEOUT_EN`, `eq_done` withheld -> `eq_timeout` = 1 after 4095 EQ_WAIT cycles, state IDLE, `lut_valid` = 0; the next `frame_start` clears `eq_timeout`.
